// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the convolution datapath.
package cnn_pkg;

  // Pixel width shared by the window generator and the MAC array.
  localparam int unsigned CNN_DATA_W = 16;

  // Width needed to hold any image dimension up to and including the maximum.
  function automatic int unsigned calc_dim_w(input int unsigned max_w, input int unsigned max_h);
    int unsigned a;
    int unsigned b;
    a = $clog2(max_w + 1);
    b = $clog2(max_h + 1);
    return (a > b) ? a : b;
  endfunction

  // Bit offset of window element (r,c) in a flattened k x k window.
  function automatic int unsigned win_off(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned data_w);
    return (r * k + c) * data_w;
  endfunction

endpackage

// File: rtl/line_delay.sv
// Runtime-length line delay: circular buffer whose output is the value written
// img_w_i enables earlier.
module line_delay #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_IMG_W = 32,
  parameter int unsigned DIM_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DIM_W-1:0]  img_w_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int unsigned AW = (MAX_IMG_W > 1) ? $clog2(MAX_IMG_W) : 1;
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  logic [DATA_W-1:0] mem_q [MAX_IMG_W];
  logic [AW-1:0]     ptr_q, ptr_d;

  // Read-before-write at the shared pointer gives exactly img_w_i cycles of delay.
  assign dout_o = mem_q[ptr_q];

  // Pointer advance with wrap at img_w_i-1; restart on a new configuration.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      if (DIM_W'(ptr_q) == img_w_i - ONE_D) ptr_d = '0;
      else                                  ptr_d = ptr_q + AW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Storage: contents need no reset, stale data is masked by the row counter.
  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K sliding-window generator for raster-order pixel streams.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W    = CNN_DATA_W,
  parameter int unsigned K         = 3,
  parameter int unsigned MAX_IMG_W = 32,
  parameter int unsigned MAX_IMG_H = 32,
  parameter int unsigned DIM_W     = calc_dim_w(MAX_IMG_W, MAX_IMG_H)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [DIM_W-1:0]      cfg_img_w,
  input  logic [DIM_W-1:0]      cfg_img_h,
  output logic                  cfg_err,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [K*K*DATA_W-1:0] out_window,
  output logic [DIM_W-1:0]      out_row,
  output logic [DIM_W-1:0]      out_col,
  output logic                  frame_done
);

  localparam int unsigned WW = K * K * DATA_W;
  localparam logic [DIM_W-1:0] K_D    = DIM_W'(K);
  localparam logic [DIM_W-1:0] KM1_D  = DIM_W'(K - 1);
  localparam logic [DIM_W-1:0] MAXW_D = DIM_W'(MAX_IMG_W);
  localparam logic [DIM_W-1:0] MAXH_D = DIM_W'(MAX_IMG_H);
  localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);

  logic [DIM_W-1:0] img_w_q, img_w_d, img_h_q, img_h_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [WW-1:0]    win_q, win_d, win_shift, out_win_q, out_win_d;
  logic             out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept, ld_clr, cfg_legal;

  logic [DATA_W-1:0] ld_dout [K-1];
  logic [DATA_W-1:0] col_in  [K];

  // Pixels arriving alongside a configuration load are dropped.
  assign accept    = in_valid & ~cfg_load;
  assign cfg_legal = (cfg_img_w >= K_D) && (cfg_img_w <= MAXW_D) &&
                     (cfg_img_h >= K_D) && (cfg_img_h <= MAXH_D);

  // Cascade of K-1 line delays; delay j yields the pixel from j+1 rows back.
  for (genvar j = 0; j < K - 1; j++) begin : g_ld
    logic [DATA_W-1:0] din;
    if (j == 0) begin : g_first
      assign din = in_data;
    end else begin : g_chain
      assign din = ld_dout[j-1];
    end
    line_delay #(
      .DATA_W   (DATA_W),
      .MAX_IMG_W(MAX_IMG_W),
      .DIM_W    (DIM_W)
    ) u_line_delay (
      .clk    (clk),
      .reset  (reset),
      .en_i   (accept),
      .clr_i  (ld_clr),
      .img_w_i(img_w_q),
      .din_i  (din),
      .dout_o (ld_dout[j])
    );
  end

  // Window shifted left by one column with the new rightmost column inserted.
  always_comb begin
    col_in[K-1] = in_data;
    for (int r = 0; r < K - 1; r++) col_in[r] = ld_dout[K-2-r];
    win_shift = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_shift[win_off(r, c, K, DATA_W) +: DATA_W] = win_q[win_off(r, c + 1, K, DATA_W) +: DATA_W];
      end
      win_shift[win_off(r, K - 1, K, DATA_W) +: DATA_W] = col_in[r];
    end
  end

  // Configuration, raster counters and registered output generation.
  always_comb begin
    img_w_d      = img_w_q;
    img_h_d      = img_h_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    cfg_err_d    = cfg_err_q;
    out_win_d    = out_win_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    ld_clr       = 1'b0;
    if (cfg_load) begin
      if (cfg_legal) begin
        img_w_d   = cfg_img_w;
        img_h_d   = cfg_img_h;
        col_d     = '0;
        row_d     = '0;
        win_d     = '0;
        cfg_err_d = 1'b0;
        ld_clr    = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (in_valid) begin
      win_d = win_shift;
      if (col_q == img_w_q - ONE_D) begin
        col_d = '0;
        row_d = (row_q == img_h_q - ONE_D) ? '0 : row_q + ONE_D;
      end else begin
        col_d = col_q + ONE_D;
      end
      // Column test also masks windows that would straddle a row wrap.
      if ((row_q >= KM1_D) && (col_q >= KM1_D)) begin
        out_valid_d  = 1'b1;
        out_win_d    = win_shift;
        out_row_d    = row_q - KM1_D;
        out_col_d    = col_q - KM1_D;
        frame_done_d = (row_q == img_h_q - ONE_D) && (col_q == img_w_q - ONE_D);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_w_q      <= MAXW_D;
      img_h_q      <= MAXH_D;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      cfg_err_q    <= 1'b0;
      out_win_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      img_w_q      <= img_w_d;
      img_h_q      <= img_h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      cfg_err_q    <= cfg_err_d;
      out_win_q    <= out_win_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cfg_err    = cfg_err_q;
  assign out_valid  = out_valid_q;
  assign out_window = out_win_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a frame-array reference model.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int MW = 32;
  localparam int MH = 32;
  localparam int DIMW = 6;
  localparam int WW = K * K * DW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_load = 1'b0;
  logic [DIMW-1:0] cfg_img_w = '0;
  logic [DIMW-1:0] cfg_img_h = '0;
  logic            cfg_err;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic [WW-1:0]   out_window;
  logic [DIMW-1:0] out_row;
  logic [DIMW-1:0] out_col;
  logic            frame_done;

  conv_window_gen #(
    .DATA_W   (DW),
    .K        (K),
    .MAX_IMG_W(MW),
    .MAX_IMG_H(MH),
    .DIM_W    (DIMW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .cfg_img_w (cfg_img_w),
    .cfg_img_h (cfg_img_h),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_window(out_window),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pixels stored by (row,col) of the current frame.
  int          pix [MH][MW];
  int          m_w, m_h, m_r, m_c;
  logic        e_valid, e_fd, e_err;
  logic [WW-1:0] e_win;
  int          e_row, e_col;

  // Windows seen on the DUT outputs in the current scenario.
  logic [WW-1:0] cap_win[$];
  int            cap_row[$];
  int            cap_col[$];
  int            cap_fd[$];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [WW-1:0] v;
    int a[9];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    v = '0;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = a[i][DW-1:0];
    return v;
  endfunction

  task automatic model_reset();
    m_w = MW; m_h = MH; m_r = 0; m_c = 0;
    e_valid = 0; e_fd = 0; e_err = 0; e_win = '0; e_row = 0; e_col = 0;
  endtask

  task automatic model_step(input logic v, input int d, input logic cl, input int cw, input int ch);
    e_valid = 0;
    e_fd = 0;
    if (cl) begin
      if (cw >= K && cw <= MW && ch >= K && ch <= MH) begin
        m_w = cw; m_h = ch; m_r = 0; m_c = 0; e_err = 0;
      end else begin
        e_err = 1;
      end
    end else if (v) begin
      pix[m_r][m_c] = d;
      if (m_r >= K - 1 && m_c >= K - 1) begin
        e_valid = 1;
        e_row = m_r - (K - 1);
        e_col = m_c - (K - 1);
        e_fd = (m_r == m_h - 1) && (m_c == m_w - 1);
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e_win[(i*K+j)*DW +: DW] = pix[e_row+i][e_col+j][DW-1:0];
      end
      m_c++;
      if (m_c == m_w) begin
        m_c = 0;
        m_r++;
        if (m_r == m_h) m_r = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic step(input logic v, input int d, input logic cl, input int cw, input int ch);
    in_valid = v;
    in_data = d[DW-1:0];
    cfg_load = cl;
    cfg_img_w = cw[DIMW-1:0];
    cfg_img_h = ch[DIMW-1:0];
    model_step(v, d, cl, cw, ch);
    @(posedge clk);
    #1;
    chk("out_valid", WW'(out_valid), WW'(e_valid));
    chk("frame_done", WW'(frame_done), WW'(e_fd));
    chk("cfg_err", WW'(cfg_err), WW'(e_err));
    chk("out_row", WW'(out_row), WW'(e_row));
    chk("out_col", WW'(out_col), WW'(e_col));
    chk("out_window", out_window, e_win);
    if (out_valid) begin
      cap_win.push_back(out_window);
      cap_row.push_back(int'(out_row));
      cap_col.push_back(int'(out_col));
      cap_fd.push_back(int'(frame_done));
    end
  endtask

  task automatic cfg(input int w, input int h);
    step(1'b0, 0, 1'b1, w, h);
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      step(1'b1, base + i, 1'b0, 0, 0);
      if (gaps) step(1'b0, 0, 1'b0, 0, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_cap();
    cap_win.delete();
    cap_row.delete();
    cap_col.delete();
    cap_fd.delete();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", WW'(out_valid), '0);
    chk("rst_window", out_window, '0);
    chk("rst_idx", WW'({out_row, out_col}), '0);
    chk("rst_fd_err", WW'({frame_done, cfg_err}), '0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", WW'(out_valid), '0);
    reset = 1'b0;
  endtask

  task automatic check_4x4_frame(input string tag, input int base);
    chk({tag, "_count"}, WW'(cap_win.size()), WW'(4));
    if (cap_win.size() == 4) begin
      chk({tag, "_first"}, cap_win[0], pk(base+0, base+1, base+2, base+4, base+5, base+6,
                                           base+8, base+9, base+10));
      chk({tag, "_first_idx"}, WW'({cap_row[0], cap_col[0]}), WW'({32'd0, 32'd0}));
      chk({tag, "_last"}, cap_win[3], pk(base+5, base+6, base+7, base+9, base+10, base+11,
                                          base+13, base+14, base+15));
      chk({tag, "_last_idx_fd"}, WW'({cap_row[3], cap_col[3], cap_fd[3]}),
          WW'({32'd1, 32'd1, 32'd1}));
    end
  endtask

  initial begin
    model_reset();
    #1;
    // Power-up reset state.
    chk("init_valid", WW'(out_valid), '0);
    chk("init_window", out_window, '0);
    chk("init_err", WW'(cfg_err), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Continuous 4x4 frame.
    cfg(4, 4);
    clear_cap();
    stream(0, 16, 1'b0);
    check_4x4_frame("cont", 0);

    // Same frame with idle gaps between pixels.
    clear_cap();
    stream(0, 16, 1'b1);
    check_4x4_frame("gaps", 0);

    // Back-to-back frames.
    clear_cap();
    stream(0, 16, 1'b0);
    stream(100, 16, 1'b0);
    chk("b2b_count", WW'(cap_win.size()), WW'(8));
    if (cap_win.size() == 8) begin
      chk("b2b_second_first", cap_win[4], pk(100, 101, 102, 104, 105, 106, 108, 109, 110));
      chk("b2b_second_idx", WW'({cap_row[4], cap_col[4]}), '0);
    end

    // Illegal width keeps 4x4; then a legal 5x3 frame.
    cfg(2, 4);
    chk("bad_cfg_err", WW'(cfg_err), WW'(1));
    clear_cap();
    stream(0, 16, 1'b0);
    chk("bad_cfg_kept", WW'(cap_win.size()), WW'(4));
    cfg(5, 3);
    chk("good_cfg_err", WW'(cfg_err), '0);
    clear_cap();
    stream(0, 15, 1'b0);
    chk("5x3_count", WW'(cap_win.size()), WW'(3));
    if (cap_win.size() == 3) begin
      chk("5x3_first", cap_win[0], pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
      chk("5x3_last_fd", WW'({cap_col[2], cap_fd[2]}), WW'({32'd2, 32'd1}));
    end

    // Reset mid-frame, then replay.
    cfg(4, 4);
    stream(0, 8, 1'b0);
    do_reset();
    cfg(4, 4);
    clear_cap();
    stream(0, 16, 1'b0);
    check_4x4_frame("rst", 0);

    // Reconfigure mid-frame, then replay.
    stream(0, 10, 1'b0);
    cfg(4, 4);
    clear_cap();
    stream(0, 16, 1'b0);
    check_4x4_frame("recfg", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming K×K sliding-window generator for the convolution datapath. It is the parametrised successor to the fixed-depth variable_shift_reg.
- Accepts one pixel per cycle in raster order, buffers K-1 image rows in runtime-length line delays, and emits a full K×K window for every valid (no-padding) convolution position.
- Sits between the input feature-map loader and the MAC array.

Parameters:
- DATA_W, 16, pixel width in bits.
- K, 3, window size (K≥2).
- MAX_IMG_W, 32, maximum supported row length.
- MAX_IMG_H, 32, maximum supported image height.
- DIM_W, $clog2(MAX_IMG_W+1) or $clog2(MAX_IMG_H+1), whichever is larger; width of dimension fields (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  single-cycle pulse; latch cfg_img_w and cfg_img_h.
- cfg_img_w  in  DIM_W  image width in pixels.
- cfg_img_h  in  DIM_W  image height in pixels.
- cfg_err  out  1  sticky; set when a cfg_load carries an illegal size.
- in_valid  in  1  in_data is a valid pixel this cycle.
- in_data  in  DATA_W  pixel value, raster order.
- out_valid  out  1  out_window holds a valid window.
- out_window  out  K*K*DATA_W  window, element (r,c) at [(r*K+c)*DATA_W +: DATA_W]. r=0 is the oldest (top) row; c=0 is the leftmost column.
- out_row  out  DIM_W  output-row index of the window, 0..img_h-K.
- out_col  out  DIM_W  output-column index of the window, 0..img_w-K.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset: counters, window registers, outputs and cfg_err go to 0. img_w and img_h reset to MAX_IMG_W and MAX_IMG_H. Line-delay storage contents are don't-care; outputs stay gated until refilled.
- Config:
  - On cfg_load, a size is legal when K ≤ img_w ≤ MAX_IMG_W and K ≤ img_h ≤ MAX_IMG_H.
  - Legal: latch the size, clear the col/row counters and the window (flushes any frame in progress), clear cfg_err.
  - Illegal: keep the old config and counters, set cfg_err.
  - in_valid in the same cycle as cfg_load is dropped.
- Pixel accept:
  - Every cycle with in_valid=1 is an accept. There is no backpressure.
  - Cycles with in_valid=0 freeze all state; gaps are allowed anywhere in the frame.
- Counters:
  - col increments per accept and wraps from img_w-1 to 0.
  - row increments on col wrap and wraps from img_h-1 to 0.
  - The next frame starts immediately; there is no idle state.
- Line delays: K-1 cascaded delays, each exactly img_w accepts long, enabled by accept. Delay j output is the pixel from j+1 rows earlier, same column.
- Window shift: on accept, every window row shifts left by one column. Column K-1 is loaded with:
  - r=K-1: in_data.
  - r=K-2: delay 0 output.
  - and so on up the rows; r=0 takes delay K-2 output.
- Output timing:
  - Latency is 1 cycle. out_valid is registered high in the cycle after an accept whose pre-increment counters satisfy row≥K-1 and col≥K-1.
  - Otherwise out_valid=0 in that cycle.
  - out_row=row-(K-1) and out_col=col-(K-1) of that accept.
  - out_window and the indices hold their values when out_valid=0.
- frame_done: registered high together with out_valid for the accept at (img_h-1, img_w-1).
- Windows never straddle a row boundary, because the column condition masks the wrap.
- Windows per frame: (img_h-K+1)*(img_w-K+1).
- Reset mid-frame: same as power-up reset; the next accepted pixel is (0,0).
- The data path is pass-through; no arithmetic on pixel values.

Decomposition:
- Shared package cnn_pkg holds:
  - the window index function (r,c) → bit offset;
  - DIM_W derivation;
  - DATA_W default constant, shared with the MAC array.
- One sub-module, line_delay (DATA_W, MAX_IMG_W):
  - enable-gated circular buffer with runtime length img_w;
  - single read/write pointer that wraps at img_w-1;
  - dout is the value written img_w enables earlier;
  - pointer resets on reset and on a legal cfg_load.
- conv_window_gen instantiates K-1 line_delay instances with a generate loop.

Test Plan:
- K=3, cfg 4×4, pixels 0..15 with in_valid every cycle:
  - exactly 4 windows;
  - first window the cycle after pixel 10 = {0,1,2,4,5,6,8,9,10}, (out_row,out_col)=(0,0);
  - last window = {5,6,7,9,10,11,13,14,15} at (1,1) with frame_done=1.
- Same stream with in_valid toggled 1,0,1,0 → identical window sequence and indices; out_valid never high in a cycle following an idle cycle.
- Back-to-back frames 0..15 then 100..115 → second frame's first window = {100,101,102,104,105,106,108,109,110}; no window mixes frames' row alignment incorrectly; 8 windows total.
- cfg_load with img_w=2 (K=3) → cfg_err=1, config unchanged; then cfg_load 5×3 → cfg_err=0, 3 windows, first = {0,1,2,5,6,7,10,11,12}.
- reset asserted after pixel 7 of a 4×4 frame, then replay 0..15 → all outputs 0 during reset; results identical to the first scenario.
- cfg_load mid-frame (after pixel 9), reload 4×4, then stream 0..15 → no stale windows; first window {0,1,2,4,5,6,8,9,10}.
